// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: sizing helpers shared by the pipelined adder and its bench
package pipe_adder_pkg;
  localparam int DEF_WIDTH = 6;
  localparam int DEF_STAGES = 3;
  function automatic int chunk_w(int width, int stages);
    return (width + stages - 1) / stages;
  endfunction
  function automatic int last_w(int width, int stages);
    return width - chunk_w(width, stages) * (stages - 1);
  endfunction
  localparam int DEF_LAST_W = last_w(DEF_WIDTH, DEF_STAGES);
endpackage

// File: rtl/adder_stage.sv
// adder_stage: one carry-chained chunk add plus its pipeline register slice
module adder_stage #(
  parameter int CW = 2,
  parameter int PW = 6,
  parameter int LO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [PW-1:0] x,
  input  logic [PW-1:0] y,
  input  logic [PW-1:0] s_in,
  input  logic          cin,
  output logic          out_valid,
  output logic [PW-1:0] x_q,
  output logic [PW-1:0] y_q,
  output logic [PW-1:0] s_q,
  output logic          cout_q
);
  logic [CW:0]   sum;
  logic [PW-1:0] s_nxt;
  // add this stage's chunk and splice it into the running partial sum
  always_comb begin
    sum = {1'b0, x[LO+:CW]} + {1'b0, y[LO+:CW]} + (CW+1)'(cin);
    s_nxt = s_in;
    s_nxt[LO+:CW] = sum[CW-1:0];
  end
  // bubbles shift like data; payload loads only with a valid operand so idle X never lands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      s_q <= '0;
      cout_q <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        x_q <= x;
        y_q <= y;
        s_q <= s_nxt;
        cout_q <= sum[CW];
      end
    end
  end
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/subtract with valid/ready streaming and overflow flag
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = chunk_w(WIDTH, STAGES);
  localparam int PW = CW * STAGES;
  localparam int L = STAGES - 1;
  logic [PW-1:0]    xq [STAGES];
  logic [PW-1:0]    yq [STAGES];
  logic [PW-1:0]    sq [STAGES];
  logic             vq [STAGES];
  logic             cq [STAGES];
  logic [WIDTH-1:0] y_eff;
  logic [PW:0]      full;
  logic             adv;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign y_eff = sub ? ~Y : Y;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [PW-1:0] xi, yi, si;
    logic          vi, ci;
    if (k == 0) begin : g_head
      assign xi = PW'(X);
      assign yi = PW'(y_eff);
      assign si = '0;
      assign vi = in_valid;
      assign ci = sub;
    end else begin : g_body
      assign xi = xq[k-1];
      assign yi = yq[k-1];
      assign si = sq[k-1];
      assign vi = vq[k-1];
      assign ci = cq[k-1];
    end
    adder_stage #(.CW(CW), .PW(PW), .LO(k * CW)) u_stage (
      .clk(clk), .rst_n(rst_n), .en(adv), .in_valid(vi),
      .x(xi), .y(yi), .s_in(si), .cin(ci),
      .out_valid(vq[k]), .x_q(xq[k]), .y_q(yq[k]), .s_q(sq[k]), .cout_q(cq[k])
    );
  end
  // zero-padded upper bits carry the true MSB carry into bit WIDTH of the padded sum
  assign full = {cq[L], sq[L]};
  assign out_valid = vq[L];
  assign S = full[WIDTH-1:0];
  assign cout = full[WIDTH];
  assign ovf = sq[L][WIDTH-1] ^ xq[L][WIDTH-1] ^ yq[L][WIDTH-1] ^ cout;
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed table, backpressure, reset and streaming checks
module tb_pipe_adder;
  import pipe_adder_pkg::*;
  typedef struct {
    logic [5:0] x;
    logic [5:0] y;
    logic       sub;
    logic [5:0] s;
    logic       c;
    logic       o;
  } vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, sub = 0;
  logic [5:0] x = 0, y = 0;
  logic [7:0] x8 = 0, y8 = 0;
  logic in_ready6, out_valid6, cout6, ovf6;
  logic [5:0] s6;
  logic in_ready_a, out_valid_a, cout_a, ovf_a;
  logic [7:0] s_a;
  logic in_ready_b, out_valid_b, cout_b, ovf_b;
  logic [7:0] s_b;
  int checks = 0, errors = 0, pops6 = 0;
  logic [9:0] q6[$], qa[$], qb[$];
  vec_t tv[11];
  always #5 clk = ~clk;
  pipe_adder #(.WIDTH(DEF_WIDTH), .STAGES(DEF_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
    .X(x), .Y(y), .sub(sub), .out_valid(out_valid6), .out_ready(out_ready),
    .S(s6), .cout(cout6), .ovf(ovf6)
  );
  pipe_adder #(.WIDTH(8), .STAGES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .X(x8), .Y(y8), .sub(sub), .out_valid(out_valid_a), .out_ready(out_ready),
    .S(s_a), .cout(cout_a), .ovf(ovf_a)
  );
  pipe_adder #(.WIDTH(8), .STAGES(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .X(x8), .Y(y8), .sub(sub), .out_valid(out_valid_b), .out_ready(out_ready),
    .S(s_b), .cout(cout_b), .ovf(ovf_b)
  );
  function automatic logic [9:0] gold(int w, logic [7:0] a, logic [7:0] b, logic sb);
    logic [8:0] m, bb, t;
    logic o;
    m = (9'd1 << w) - 9'd1;
    bb = (sb ? ~{1'b0, b} : {1'b0, b}) & m;
    t = {1'b0, a} + bb + 9'(sb);
    o = (a[w-1] == bb[w-1]) && (t[w-1] != a[w-1]);
    return {o, t[w], t[7:0] & m[7:0]};
  endfunction
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic pop_chk(string n, int sz, logic [9:0] exp, logic [9:0] act);
    checks++;
    if (sz == 0) begin
      errors++;
      $display("FAIL %s unexpected result %h", n, act);
    end else if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  // scoreboards: push on input transfer, compare on output transfer, flush on reset
  always @(negedge clk) begin
    if (!rst_n) begin
      q6.delete();
      qa.delete();
      qb.delete();
    end else begin
      if (in_valid && in_ready6) q6.push_back(gold(6, {2'b0, x}, {2'b0, y}, sub));
      if (in_valid && in_ready_a) qa.push_back(gold(8, x8, y8, sub));
      if (in_valid && in_ready_b) qb.push_back(gold(8, x8, y8, sub));
      if (out_valid6 && out_ready) begin
        pop_chk("out6", q6.size(), q6.size() ? q6[0] : '0, {ovf6, cout6, 2'b0, s6});
        if (q6.size() != 0) void'(q6.pop_front());
        pops6++;
      end
      if (out_valid_a && out_ready) begin
        pop_chk("out8a", qa.size(), qa.size() ? qa[0] : '0, {ovf_a, cout_a, s_a});
        if (qa.size() != 0) void'(qa.pop_front());
      end
      if (out_valid_b && out_ready) begin
        pop_chk("out8b", qb.size(), qb.size() ? qb[0] : '0, {ovf_b, cout_b, s_b});
        if (qb.size() != 0) void'(qb.pop_front());
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(vec_t v);
    x = v.x;
    y = v.y;
    sub = v.sub;
    x8 = {2'b0, v.x};
    y8 = {2'b0, v.y};
  endtask
  task automatic run_vec(string n, vec_t v);
    int lat = 0;
    drive(v);
    in_valid = 1;
    @(negedge clk);
    chk({n, "_in_ready"}, in_ready6, 1);
    do begin
      @(posedge clk);
      #1 in_valid = 0;
      lat++;
      @(negedge clk);
    end while (!out_valid6 && lat < 10);
    chk({n, "_latency"}, lat, 3);
    chk({n, "_s"}, s6, v.s);
    chk({n, "_cout"}, cout6, v.c);
    chk({n, "_ovf"}, ovf6, v.o);
    step();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int k, stalls, p0;
    tv[0]  = '{6'd63, 6'd1,  1'b0, 6'd0,  1'b1, 1'b0};
    tv[1]  = '{6'd5,  6'd7,  1'b1, 6'd62, 1'b0, 1'b0};
    tv[2]  = '{6'd7,  6'd5,  1'b1, 6'd2,  1'b1, 1'b0};
    tv[3]  = '{6'd31, 6'd1,  1'b0, 6'd32, 1'b0, 1'b1};
    tv[4]  = '{6'd32, 6'd1,  1'b1, 6'd31, 1'b1, 1'b1};
    tv[5]  = '{6'd0,  6'd0,  1'b0, 6'd0,  1'b0, 1'b0};
    tv[6]  = '{6'd0,  6'd0,  1'b1, 6'd0,  1'b1, 1'b0};
    tv[7]  = '{6'd32, 6'd32, 1'b0, 6'd0,  1'b1, 1'b1};
    tv[8]  = '{6'd21, 6'd42, 1'b0, 6'd63, 1'b0, 1'b0};
    tv[9]  = '{6'd1,  6'd2,  1'b1, 6'd63, 1'b0, 1'b0};
    tv[10] = '{6'd0,  6'd32, 1'b1, 6'd32, 1'b0, 1'b1};
    repeat (3) step();
    @(negedge clk);
    chk("rst_out_valid", out_valid6, 0);
    chk("rst_s", s6, 0);
    chk("rst_cout", cout6, 0);
    chk("rst_ovf", ovf6, 0);
    chk("rst_in_ready", in_ready6, 1);
    chk("rst_out_valid_8a", out_valid_a, 0);
    chk("rst_out_valid_8b", out_valid_b, 0);
    step();
    rst_n = 1;
    step();
    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), tv[i]);
    k = 0;
    for (int c = 0; c < 40 && !(k == 5 && q6.size() == 0); c++) begin
      out_ready = !(c >= 3 && c < 7);
      in_valid = k < 5;
      if (k < 5) drive(tv[k]);
      @(negedge clk);
      if (c >= 3 && c < 7) begin
        chk("bp_in_ready", in_ready6, 0);
        chk("bp_out_valid", out_valid6, 1);
        chk("bp_hold_s", s6, tv[0].s);
        chk("bp_hold_cout", cout6, tv[0].c);
        chk("bp_hold_ovf", ovf6, tv[0].o);
      end
      if (in_valid && in_ready6) k++;
      step();
    end
    in_valid = 0;
    out_ready = 1;
    chk("bp_accepted", k, 5);
    chk("bp_drained", q6.size(), 0);
    drive(tv[1]);
    in_valid = 1;
    step();
    drive(tv[2]);
    step();
    in_valid = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid6, 0);
    chk("midrst_s", s6, 0);
    chk("midrst_cout", cout6, 0);
    chk("midrst_ovf", ovf6, 0);
    step();
    repeat (12) step();
    run_vec("post_rst", tv[3]);
    stalls = 0;
    p0 = pops6;
    for (int i = 0; i < 8192; i++) begin
      sub = i[12];
      x = i[11:6];
      y = i[5:0];
      x8 = {i[1:0], i[11:6]};
      y8 = {i[7:6], i[5:0]};
      in_valid = 1;
      @(negedge clk);
      if (!in_ready6) stalls++;
      step();
    end
    in_valid = 0;
    chk("ex_stalls", stalls, 0);
    @(posedge clk);
    @(negedge clk);
    #1 chk("ex_tail_one_left", q6.size(), 1);
    @(negedge clk);
    #1 chk("ex_tail_empty", q6.size(), 0);
    chk("ex_result_count", pops6 - p0, 8192);
    for (int n = 0; n < 20 && (qa.size() != 0 || qb.size() != 0); n++) step();
    chk("ex_drain_8a", qa.size(), 0);
    chk("ex_drain_8b", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
